// File: rtl/cp0_exc_unit.sv
// CP0 register file and precise-exception resolver sitting at the WB stage.
// Resolves interrupt / exception / ERET / MTC0 priority and drives the flush-redirect bus.
module cp0_exc_unit #(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic                                          wb_valid,
  input  logic [31:0]                                   wb_pc,
  input  logic                                          wb_is_ds,
  input  logic                                          wb_exc,
  input  logic [4:0]                                    wb_exc_code,
  input  logic                                          wb_bad_we,
  input  logic [31:0]                                   wb_badvaddr,
  input  logic                                          wb_eret,
  input  logic                                          wb_mtc0,
  input  logic [7:0]                                    cp0_addr,
  input  logic [31:0]                                   cp0_wdata,
  output logic [31:0]                                   cp0_rdata,
  input  logic [((NUM_HW_INT > 0) ? NUM_HW_INT : 1)-1:0] hw_int,
  output logic                                          commit,
  output logic                                          flush,
  output logic [31:0]                                   flush_pc,
  output logic [31:0]                                   status_o,
  output logic [31:0]                                   cause_o,
  output logic [31:0]                                   epc_o
);

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;
  localparam logic [3:0] PRESC_LAST    = 4'(COUNT_DIV - 1);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [3:0]  presc;

  logic [5:0]  hw_ext;
  logic [7:0]  cause_ip;
  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic        int_req;
  logic        take_exc;
  logic        do_eret;
  logic        mtc0_we;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        count_tick;
  logic        timer_hit;

  // Unused interrupt lines tie off to zero so IP bits beyond NUM_HW_INT read 0.
  for (genvar gi = 0; gi < 6; gi++) begin : g_hw
    if (gi < NUM_HW_INT) begin : g_on
      assign hw_ext[gi] = hw_int[gi];
    end else begin : g_off
      assign hw_ext[gi] = 1'b0;
    end
  end

  assign cause_ip   = {ip_hw[5] | cause_ti, ip_hw[4:0], ip_sw};
  assign status_val = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_val  = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, exc_code, 2'b0};

  assign int_req  = status_ie & ~status_exl & (|(cause_ip & status_im));
  assign flush    = resetn & wb_valid & (int_req | wb_exc | wb_eret);
  assign commit   = resetn & wb_valid & ~flush;
  assign take_exc = flush & (int_req | wb_exc);
  assign do_eret  = flush & ~int_req & ~wb_exc;
  assign flush_pc = (int_req | wb_exc) ? EXC_VECTOR : epc;

  assign mtc0_we    = commit & wb_mtc0;
  assign wr_count   = mtc0_we & (cp0_addr == ADDR_COUNT);
  assign wr_compare = mtc0_we & (cp0_addr == ADDR_COMPARE);
  assign wr_status  = mtc0_we & (cp0_addr == ADDR_STATUS);
  assign wr_cause   = mtc0_we & (cp0_addr == ADDR_CAUSE);
  assign wr_epc     = mtc0_we & (cp0_addr == ADDR_EPC);

  assign count_tick = (presc == PRESC_LAST);
  assign timer_hit  = (count == compare);

  assign status_o = status_val;
  assign cause_o  = cause_val;
  assign epc_o    = epc;

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_COMPARE:  cp0_rdata = compare;
      ADDR_STATUS:   cp0_rdata = status_val;
      ADDR_CAUSE:    cp0_rdata = cause_val;
      ADDR_EPC:      cp0_rdata = epc;
      default:       cp0_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_im  <= 8'h0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (take_exc) begin
      status_exl <= 1'b1;
    end else if (do_eret) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= cp0_wdata[15:8];
      status_exl <= cp0_wdata[1];
      status_ie  <= cp0_wdata[0];
    end
  end

  // IP and TI keep running while WB is idle; BD/ExcCode/IP_sw only move on a WB event.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cause_bd <= 1'b0;
      cause_ti <= 1'b0;
      ip_hw    <= 6'h0;
      ip_sw    <= 2'h0;
      exc_code <= 5'h0;
    end else begin
      ip_hw <= hw_ext;
      if (wr_compare) begin
        cause_ti <= 1'b0;
      end else if (timer_hit) begin
        cause_ti <= 1'b1;
      end
      if (take_exc) begin
        exc_code <= int_req ? 5'd0 : wb_exc_code;
        if (!status_exl) begin
          cause_bd <= wb_is_ds;
        end
      end else if (wr_cause) begin
        ip_sw <= cp0_wdata[9:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      epc <= 32'h0;
    end else if (take_exc) begin
      if (!status_exl) begin
        epc <= wb_is_ds ? (wb_pc - 32'd4) : wb_pc;
      end
    end else if (wr_epc) begin
      epc <= cp0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr <= 32'h0;
    end else if (take_exc && wb_bad_we && !int_req) begin
      badvaddr <= wb_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= 32'h0;
      presc <= 4'h0;
    end else if (wr_count) begin
      count <= cp0_wdata;
      presc <= 4'h0;
    end else if (count_tick) begin
      count <= count + 32'd1;
      presc <= 4'h0;
    end else begin
      presc <= presc + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      compare <= 32'h0;
    end else if (wr_compare) begin
      compare <= cp0_wdata;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios plus random traffic against a reference model.
module tb_cp0_exc_unit;
  localparam int          COUNT_DIV = 2;
  localparam logic [31:0] VEC       = 32'hBFC0_0380;
  localparam logic [7:0]  A_BAD = 8'h40, A_COUNT = 8'h48, A_CMP = 8'h58;
  localparam logic [7:0]  A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  logic clk = 1'b0;
  logic resetn, wb_valid, wb_is_ds, wb_exc, wb_bad_we, wb_eret, wb_mtc0;
  logic [31:0] wb_pc, wb_badvaddr, cp0_wdata;
  logic [4:0]  wb_exc_code;
  logic [7:0]  cp0_addr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata, flush_pc, status_o, cause_o, epc_o;
  logic        commit, flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cp0_exc_unit #(.NUM_HW_INT(6), .EXC_VECTOR(VEC), .COUNT_DIV(COUNT_DIV)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_is_ds(wb_is_ds),
    .wb_exc(wb_exc), .wb_exc_code(wb_exc_code), .wb_bad_we(wb_bad_we), .wb_badvaddr(wb_badvaddr),
    .wb_eret(wb_eret), .wb_mtc0(wb_mtc0), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .hw_int(hw_int), .commit(commit), .flush(flush), .flush_pc(flush_pc),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  // Reference model state, one variable per architectural field.
  logic [7:0]  m_im = 0;
  logic        m_exl = 0, m_ie = 0, m_bd = 0, m_ti = 0;
  logic [5:0]  m_hw = 0;
  logic [1:0]  m_sw = 0;
  logic [4:0]  m_code = 0;
  logic [31:0] m_epc = 0, m_bad = 0, m_count = 0, m_cmp = 0;
  int          m_presc = 0;

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
  endfunction

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
  endfunction

  function automatic logic m_pending();
    return m_ie && !m_exl && ((m_ip() & m_im) != 8'h0);
  endfunction

  function automatic logic m_flush();
    return resetn && wb_valid && (m_pending() || wb_exc || wb_eret);
  endfunction

  function automatic logic [31:0] m_flush_pc();
    return (m_pending() || wb_exc) ? VEC : m_epc;
  endfunction

  function automatic logic [31:0] m_rdata();
    case (cp0_addr)
      A_BAD:    return m_bad;
      A_COUNT:  return m_count;
      A_CMP:    return m_cmp;
      A_STATUS: return m_status();
      A_CAUSE:  return m_cause();
      A_EPC:    return m_epc;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic hit, pend, take, er, wr;
    if (!resetn) begin
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_hw = 0; m_sw = 0; m_code = 0;
      m_epc = 0; m_bad = 0; m_count = 0; m_cmp = 0; m_presc = 0;
      return;
    end
    hit  = (m_count == m_cmp);
    pend = m_pending();
    take = wb_valid && (pend || wb_exc);
    er   = wb_valid && !pend && !wb_exc && wb_eret;
    wr   = wb_valid && !(pend || wb_exc || wb_eret) && wb_mtc0;
    if (wr && cp0_addr == A_COUNT) begin
      m_count = cp0_wdata; m_presc = 0;
    end else begin
      m_presc = m_presc + 1;
      if (m_presc == COUNT_DIV) begin m_presc = 0; m_count = m_count + 1; end
    end
    if (wr && cp0_addr == A_CMP) begin m_ti = 0; m_cmp = cp0_wdata; end
    else if (hit) m_ti = 1;
    m_hw = hw_int;
    if (take) begin
      m_code = pend ? 5'd0 : wb_exc_code;
      if (!m_exl) begin m_epc = wb_is_ds ? wb_pc - 32'd4 : wb_pc; m_bd = wb_is_ds; end
      m_exl = 1;
      if (wb_bad_we && !pend) m_bad = wb_badvaddr;
    end
    if (er) m_exl = 0;
    if (wr) begin
      if (cp0_addr == A_STATUS) begin m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
      if (cp0_addr == A_CAUSE) m_sw = cp0_wdata[9:8];
      if (cp0_addr == A_EPC) m_epc = cp0_wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    wb_valid = 0; wb_pc = 0; wb_is_ds = 0; wb_exc = 0; wb_exc_code = 0; wb_bad_we = 0;
    wb_badvaddr = 0; wb_eret = 0; wb_mtc0 = 0; cp0_addr = 0; cp0_wdata = 0; hw_int = 0;
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    clear_inputs();
    wb_valid = 1; wb_mtc0 = 1; cp0_addr = addr; cp0_wdata = data;
    #1;
    checks++; if (commit !== 1'b1) begin errors++; $display("FAIL mtc0_commit addr=%h: got %b want 1", addr, commit); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    resetn = 0; clear_inputs();
    wb_valid = 1; wb_exc = 1; wb_eret = 1;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b want 0", commit); end
    tick(); tick();
    clear_inputs(); cp0_addr = A_COUNT; #1;
    checks++; if (status_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h want 00400000", status_o); end
    checks++; if (cause_o !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h want 0", cause_o); end
    checks++; if (epc_o !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", epc_o); end
    checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", cp0_rdata); end
    resetn = 1; clear_inputs();
    tick();
  endtask

  task automatic test_syscall();
    clear_inputs();
    wb_valid = 1; wb_pc = 32'hBFC0_0100; wb_exc = 1; wb_exc_code = 5'd8;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL sys_flush: got %b want 1", flush); end
    checks++; if (flush_pc !== VEC) begin errors++; $display("FAIL sys_flush_pc: got %h want %h", flush_pc, VEC); end
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL sys_commit: got %b want 0", commit); end
    tick();
    checks++; if (epc_o !== 32'hBFC0_0100) begin errors++; $display("FAIL sys_epc: got %h want bfc00100", epc_o); end
    checks++; if (cause_o[6:2] !== 5'd8) begin errors++; $display("FAIL sys_code: got %0d want 8", cause_o[6:2]); end
    checks++; if (status_o[1] !== 1'b1) begin errors++; $display("FAIL sys_exl: got %b want 1", status_o[1]); end
    checks++; if (cause_o[31] !== 1'b0) begin errors++; $display("FAIL sys_bd: got %b want 0", cause_o[31]); end
    clear_inputs();
  endtask

  task automatic test_eret(input logic [31:0] exp_pc);
    clear_inputs();
    wb_valid = 1; wb_eret = 1;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush: got %b want 1", flush); end
    checks++; if (flush_pc !== exp_pc) begin errors++; $display("FAIL eret_flush_pc: got %h want %h", flush_pc, exp_pc); end
    tick();
    checks++; if (status_o[1] !== 1'b0) begin errors++; $display("FAIL eret_exl: got %b want 0", status_o[1]); end
    clear_inputs();
  endtask

  task automatic test_ds_adel();
    clear_inputs();
    wb_valid = 1; wb_pc = 32'hBFC0_0204; wb_is_ds = 1; wb_exc = 1; wb_exc_code = 5'd4;
    wb_bad_we = 1; wb_badvaddr = 32'h0000_1001;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ds_flush: got %b want 1", flush); end
    tick();
    clear_inputs(); cp0_addr = A_BAD; #1;
    checks++; if (epc_o !== 32'hBFC0_0200) begin errors++; $display("FAIL ds_epc: got %h want bfc00200", epc_o); end
    checks++; if (cause_o[31] !== 1'b1) begin errors++; $display("FAIL ds_bd: got %b want 1", cause_o[31]); end
    checks++; if (cause_o[6:2] !== 5'd4) begin errors++; $display("FAIL ds_code: got %0d want 4", cause_o[6:2]); end
    checks++; if (cp0_rdata !== 32'h0000_1001) begin errors++; $display("FAIL ds_badvaddr: got %h want 00001001", cp0_rdata); end
    clear_inputs();
  endtask

  task automatic test_nested();
    clear_inputs();
    wb_valid = 1; wb_pc = 32'hBFC0_0400; wb_exc = 1; wb_exc_code = 5'd12;
    #1;
    checks++; if (flush_pc !== VEC) begin errors++; $display("FAIL nest_flush_pc: got %h want %h", flush_pc, VEC); end
    tick();
    checks++; if (epc_o !== 32'hBFC0_0200) begin errors++; $display("FAIL nest_epc: got %h want bfc00200", epc_o); end
    checks++; if (cause_o[6:2] !== 5'd12) begin errors++; $display("FAIL nest_code: got %0d want 12", cause_o[6:2]); end
    checks++; if (cause_o[31] !== 1'b1) begin errors++; $display("FAIL nest_bd: got %b want 1", cause_o[31]); end
    clear_inputs();
  endtask

  task automatic test_timer();
    int n;
    mtc0(A_COUNT, 32'h0);
    n = 0;
    // Old Compare (0) equals Count (0) on this edge, yet the Compare write must win.
    mtc0(A_CMP, 32'd5); n++;
    checks++; if (cause_o[30] !== 1'b0) begin errors++; $display("FAIL timer_clear_wins: got %b want 0", cause_o[30]); end
    mtc0(A_STATUS, 32'h0000_8001); n++;
    while (cause_o[30] !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 11) begin errors++; $display("FAIL timer_latency: got %0d want 11 clocks", n); end
    wb_valid = 1; wb_pc = 32'hBFC0_0500;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL timer_int_flush: got %b want 1", flush); end
    checks++; if (flush_pc !== VEC) begin errors++; $display("FAIL timer_int_pc: got %h want %h", flush_pc, VEC); end
    tick();
    checks++; if (cause_o[6:2] !== 5'd0) begin errors++; $display("FAIL timer_code: got %0d want 0", cause_o[6:2]); end
    checks++; if (epc_o !== 32'hBFC0_0500) begin errors++; $display("FAIL timer_epc: got %h want bfc00500", epc_o); end
    mtc0(A_CMP, 32'h0);
    checks++; if (cause_o[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_clear: got %b want 0", cause_o[30]); end
    mtc0(A_STATUS, 32'h0);
  endtask

  task automatic test_hw_int();
    clear_inputs(); hw_int = 6'b000001;
    wb_valid = 1; wb_mtc0 = 1; cp0_addr = A_STATUS; cp0_wdata = 32'h0000_0401;
    tick();
    clear_inputs(); hw_int = 6'b000001;
    wb_valid = 1; wb_pc = 32'hBFC0_0600; wb_exc = 1; wb_exc_code = 5'd5;
    wb_bad_we = 1; wb_badvaddr = 32'hDEAD_BEEF;
    #1;
    checks++; if (flush_pc !== VEC) begin errors++; $display("FAIL hwint_flush_pc: got %h want %h", flush_pc, VEC); end
    tick();
    clear_inputs(); cp0_addr = A_BAD; #1;
    checks++; if (cause_o[6:2] !== 5'd0) begin errors++; $display("FAIL hwint_code: got %0d want 0", cause_o[6:2]); end
    checks++; if (cause_o[10] !== 1'b1) begin errors++; $display("FAIL hwint_ip2: got %b want 1", cause_o[10]); end
    checks++; if (cp0_rdata !== 32'h0000_1001) begin errors++; $display("FAIL hwint_badvaddr: got %h want 00001001", cp0_rdata); end
    checks++; if (epc_o !== 32'hBFC0_0600) begin errors++; $display("FAIL hwint_epc: got %h want bfc00600", epc_o); end
    mtc0(A_STATUS, 32'h0);
  endtask

  task automatic test_flushed_mtc0();
    clear_inputs();
    wb_valid = 1; wb_exc = 1; wb_exc_code = 5'd10; wb_pc = 32'hBFC0_0700;
    wb_mtc0 = 1; cp0_addr = A_STATUS; cp0_wdata = 32'hFFFF_FF01;
    #1;
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL fmtc0_commit: got %b want 0", commit); end
    tick();
    checks++; if (status_o !== 32'h0040_0002) begin errors++; $display("FAIL fmtc0_status: got %h want 00400002", status_o); end
    mtc0(A_STATUS, 32'h0);
  endtask

  task automatic test_count_wrap();
    mtc0(A_COUNT, 32'hFFFF_FFFF);
    cp0_addr = A_COUNT; #1;
    checks++; if (cp0_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_load: got %h want ffffffff", cp0_rdata); end
    tick();
    checks++; if (cp0_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_hold: got %h want ffffffff", cp0_rdata); end
    tick();
    checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", cp0_rdata); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    mtc0(A_STATUS, 32'h0000_FF01);
    resetn = 0; clear_inputs();
    wb_valid = 1; wb_exc = 1; wb_mtc0 = 1; cp0_addr = A_STATUS; cp0_wdata = 32'hFFFF_FFFF; hw_int = 6'h3F;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rmid_flush: got %b want 0", flush); end
    tick();
    clear_inputs(); cp0_addr = A_COUNT; #1;
    checks++; if (status_o !== 32'h0040_0000) begin errors++; $display("FAIL rmid_status: got %h want 00400000", status_o); end
    checks++; if (cause_o !== 32'h0) begin errors++; $display("FAIL rmid_cause: got %h want 0", cause_o); end
    checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL rmid_count: got %h want 0", cp0_rdata); end
    resetn = 1; clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] codes [6];
    codes[0] = 4; codes[1] = 5; codes[2] = 8; codes[3] = 9; codes[4] = 10; codes[5] = 12;
    for (int i = 0; i < 800; i++) begin
      resetn      = ($urandom_range(0, 99) >= 2);
      wb_valid    = ($urandom_range(0, 9) < 7);
      wb_pc       = {$urandom(), 2'b00};
      wb_is_ds    = $urandom_range(0, 1);
      wb_exc      = ($urandom_range(0, 9) < 2);
      wb_exc_code = codes[$urandom_range(0, 5)];
      wb_bad_we   = $urandom_range(0, 1);
      wb_badvaddr = $urandom();
      wb_eret     = ($urandom_range(0, 9) < 1);
      wb_mtc0     = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 6))
        0: cp0_addr = A_BAD;
        1: cp0_addr = A_COUNT;
        2: cp0_addr = A_CMP;
        3: cp0_addr = A_STATUS;
        4: cp0_addr = A_CAUSE;
        5: cp0_addr = A_EPC;
        default: cp0_addr = 8'($urandom());
      endcase
      cp0_wdata = $urandom();
      if (cp0_addr == A_CMP && $urandom_range(0, 1) == 1) cp0_wdata = m_count + 32'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) hw_int = 6'($urandom());
      #1;
      checks++; if (flush !== m_flush()) begin errors++; $display("FAIL rnd_flush @%0d: got %b want %b", i, flush, m_flush()); end
      checks++; if (commit !== (resetn && wb_valid && !m_flush())) begin errors++; $display("FAIL rnd_commit @%0d: got %b", i, commit); end
      checks++; if (cp0_rdata !== m_rdata()) begin errors++; $display("FAIL rnd_rdata @%0d addr=%h: got %h want %h", i, cp0_addr, cp0_rdata, m_rdata()); end
      if (m_flush()) begin
        checks++; if (flush_pc !== m_flush_pc()) begin errors++; $display("FAIL rnd_flush_pc @%0d: got %h want %h", i, flush_pc, m_flush_pc()); end
      end
      tick();
      checks++; if (status_o !== m_status()) begin errors++; $display("FAIL rnd_status @%0d: got %h want %h", i, status_o, m_status()); end
      checks++; if (cause_o !== m_cause()) begin errors++; $display("FAIL rnd_cause @%0d: got %h want %h", i, cause_o, m_cause()); end
      checks++; if (epc_o !== m_epc) begin errors++; $display("FAIL rnd_epc @%0d: got %h want %h", i, epc_o, m_epc); end
    end
    resetn = 1; clear_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    clear_inputs();
    test_reset();
    test_syscall();
    test_eret(32'hBFC0_0100);
    test_ds_adel();
    test_nested();
    test_eret(32'hBFC0_0200);
    test_timer();
    test_hw_int();
    test_flushed_mtc0();
    test_count_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
